mem_seq: RTL and testbench

- Parametrised successor to the main-bus memory block.
- Adds a registered address latch with post-increment, a programmable write wait-state sequencer with a busy flag, and a synchronous read path to the mem bus.
- Sits between the 8-bit main bus and the RAM array. The direction, assert and load controls keep the same sense as the existing memory block, so the control unit can drive either block.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_seq_if.sv | 30 +++
 rtl/mem_array.sv | 40 ++++
 rtl/mem_seq.sv | 179 +++++++++++++++++
 tb/tb_mem_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the mem_seq memory sequencer.
package mem_pkg;

  // Write sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_WIDTH_ADDR = 16;

  // Bus direction encoding, same sense as the existing memory block.
  localparam logic DIR_MAIN_TO_MEM = 1'b0;
  localparam logic DIR_MEM_TO_MAIN = 1'b1;

endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: main-bus / mem-bus signal bundle for mem_seq.
// master = control unit side, slave = memory sequencer side.
interface mem_seq_if #(
  parameter int WIDTH      = mem_pkg::DEF_WIDTH,
  parameter int WIDTH_ADDR = mem_pkg::DEF_WIDTH_ADDR
);
  logic [WIDTH_ADDR-1:0] addr_in;
  logic                  addr_load;
  logic                  inc;
  logic                  bus_dir;
  logic [WIDTH-1:0]      main_in;
  logic                  assert_main;
  logic                  load_main;
  logic [WIDTH-1:0]      main_out;
  logic                  main_en;
  logic [WIDTH-1:0]      bus_out;
  logic [WIDTH_ADDR-1:0] addr_out;
  logic                  busy;
  logic                  wr_err;

  modport master (
    output addr_in, addr_load, inc, bus_dir, main_in, assert_main, load_main,
    input  main_out, main_en, bus_out, addr_out, busy, wr_err
  );

  modport slave (
    input  addr_in, addr_load, inc, bus_dir, main_in, assert_main, load_main,
    output main_out, main_en, bus_out, addr_out, busy, wr_err
  );
endinterface

// File: rtl/mem_array.sv
// mem_array: RAM with one write port and one registered read port.
// A read of the address being written returns the old word.
module mem_array
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int WIDTH_ADDR = DEF_WIDTH_ADDR
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [WIDTH_ADDR-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [WIDTH_ADDR-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);
  localparam int DEPTH = 2 ** WIDTH_ADDR;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port, cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= {WIDTH{1'b0}};
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_seq.sv
// mem_seq: address latch with post-increment, write wait-state sequencer
// and synchronous read path between the main bus and the RAM array.
// Optional build macro: MEM_ROM_PROTECT_EN blocks writes below ROM_TOP and
// raises a sticky wr_err flag instead.
module mem_seq
  import mem_pkg::*;
#(
  parameter int                    WIDTH       = DEF_WIDTH,
  parameter int                    WIDTH_ADDR  = DEF_WIDTH_ADDR,
  parameter int                    WAIT_STATES = 0,
  parameter logic [WIDTH_ADDR-1:0] ROM_TOP     = WIDTH_ADDR'(16'h8000)
) (
  input logic      clk,
  input logic      reset,
  mem_seq_if.slave bus
);
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);
  localparam bit                    ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [WIDTH_ADDR-1:0] ADDR_ONE  = WIDTH_ADDR'(1);

`ifdef MEM_ROM_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  state_e                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [WIDTH_ADDR-1:0] r_addr, w_addr_nxt;
  logic [WIDTH_ADDR-1:0] r_pend_addr;
  logic [WIDTH-1:0]      r_pend_data;
  logic                  r_pend_inc;
  logic                  r_pend_block;

  logic                  w_wr_req;
  logic                  w_post_inc;
  logic [WIDTH_ADDR-1:0] w_eff_addr;
  logic                  w_block;
  logic                  w_capture;
  logic                  w_commit;
  logic                  w_commit_block;
  logic                  w_we;
  logic [WIDTH_ADDR-1:0] w_waddr;
  logic [WIDTH-1:0]      w_wdata;
  logic [WIDTH-1:0]      w_rd;
  logic                  w_busy;

  // A write uses addr_in when the address is being loaded on the same edge.
  assign w_wr_req   = ~bus.load_main & (bus.bus_dir == DIR_MAIN_TO_MEM);
  assign w_post_inc = ~bus.inc & bus.addr_load;
  assign w_eff_addr = bus.addr_load ? r_addr : bus.addr_in;
  assign w_block    = PROTECT_EN & (w_eff_addr < ROM_TOP);
  assign w_we       = w_commit & ~w_commit_block;
  assign w_busy     = (r_state == WAIT);

  // Next-state, address update and write-port selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_capture      = 1'b0;
    w_commit       = 1'b0;
    w_commit_block = 1'b0;
    w_waddr        = w_eff_addr;
    w_wdata        = bus.main_in;
    case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          if (ZERO_WAIT) begin
            w_commit       = 1'b1;
            w_commit_block = w_block;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
        // With wait states, a post-increment requested with a write is
        // deferred to the commit edge.
        if (!bus.addr_load) begin
          w_addr_nxt = bus.addr_in;
        end else if (w_post_inc && (ZERO_WAIT || !w_wr_req)) begin
          w_addr_nxt = r_addr + ADDR_ONE;
        end else begin
          w_addr_nxt = r_addr;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_commit       = 1'b1;
          w_commit_block = r_pend_block;
          w_waddr        = r_pend_addr;
          w_wdata        = r_pend_data;
          w_state_nxt    = IDLE;
          if (r_pend_inc) begin
            w_addr_nxt = r_addr + ADDR_ONE;
          end else begin
            w_addr_nxt = r_addr;
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, wait counter and address register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= {WIDTH_ADDR{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Capture of a write request that must wait before committing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_addr  <= {WIDTH_ADDR{1'b0}};
      r_pend_data  <= {WIDTH{1'b0}};
      r_pend_inc   <= 1'b0;
      r_pend_block <= 1'b0;
    end else if (w_capture) begin
      r_pend_addr  <= w_eff_addr;
      r_pend_data  <= bus.main_in;
      r_pend_inc   <= w_post_inc;
      r_pend_block <= w_block;
    end
  end

`ifdef MEM_ROM_PROTECT_EN
  logic r_wr_err;

  // Sticky flag for a write that targeted the protected region.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_err <= 1'b0;
    end else if (w_commit && w_commit_block) begin
      r_wr_err <= 1'b1;
    end
  end

  assign bus.wr_err = r_wr_err;
`else
  assign bus.wr_err = 1'b0;
`endif

  mem_array #(
    .WIDTH      (WIDTH),
    .WIDTH_ADDR (WIDTH_ADDR)
  ) u_mem_array (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_rd)
  );

  assign bus.main_out = w_rd;
  assign bus.bus_out  = w_rd;
  assign bus.addr_out = r_addr;
  assign bus.busy     = w_busy;
  assign bus.main_en  = reset & (bus.bus_dir == DIR_MEM_TO_MAIN) &
                        ~bus.assert_main & ~w_busy;

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: drives one zero-wait and one three-wait-state mem_seq with the
// same stimulus and checks both against a cycle-level behavioural model.
module tb_mem_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr_in;
  logic        addr_load, inc, bus_dir, assert_main, load_main;
  logic [7:0]  main_in;

  mem_seq_if #(.WIDTH(8), .WIDTH_ADDR(16)) if0 ();
  mem_seq_if #(.WIDTH(8), .WIDTH_ADDR(16)) if3 ();

  assign if0.addr_in     = addr_in;
  assign if0.addr_load   = addr_load;
  assign if0.inc         = inc;
  assign if0.bus_dir     = bus_dir;
  assign if0.main_in     = main_in;
  assign if0.assert_main = assert_main;
  assign if0.load_main   = load_main;
  assign if3.addr_in     = addr_in;
  assign if3.addr_load   = addr_load;
  assign if3.inc         = inc;
  assign if3.bus_dir     = bus_dir;
  assign if3.main_in     = main_in;
  assign if3.assert_main = assert_main;
  assign if3.load_main   = load_main;

  mem_seq #(.WIDTH(8), .WIDTH_ADDR(16), .WAIT_STATES(0), .ROM_TOP(16'h8000))
    u_dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  mem_seq #(.WIDTH(8), .WIDTH_ADDR(16), .WAIT_STATES(3), .ROM_TOP(16'h8000))
    u_dut3 (.clk(clk), .reset(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_ROM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam logic [15:0] ROM_TOP = 16'h8000;

  int errors = 0;
  int checks = 0;

  // Reference model: per-DUT storage image plus pending-write bookkeeping
  // expressed as an absolute commit cycle.
  int          ws [2];
  logic [7:0]  m_mem   [2][65536];
  bit          m_known [2][65536];
  logic [15:0] m_addr [2];
  logic [7:0]  m_rd [2];
  bit          m_rd_known [2];
  bit          m_pend [2];
  int          m_commit_t [2];
  logic [15:0] m_paddr [2];
  logic [7:0]  m_pdata [2];
  bit          m_pinc [2];
  bit          m_err [2];
  int          cyc;

  task automatic model_write(input int m, input logic [15:0] a, input logic [7:0] d);
    if (PROT && (a < ROM_TOP)) begin
      m_err[m] = 1'b1;
    end else begin
      m_mem[m][a]   = d;
      m_known[m][a] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_addr[m]     = 16'h0000;
      m_rd[m]       = 8'h00;
      m_rd_known[m] = 1'b1;
      m_pend[m]     = 1'b0;
      m_err[m]      = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      logic [7:0]  nrd;
      bit          nkn;
      logic [15:0] eff;
      bit          wr;
      bit          pinc;
      nrd = m_mem[m][m_addr[m]];
      nkn = m_known[m][m_addr[m]];
      if (m_pend[m]) begin
        if (cyc == m_commit_t[m]) begin
          model_write(m, m_paddr[m], m_pdata[m]);
          if (m_pinc[m]) m_addr[m] = m_addr[m] + 16'd1;
          m_pend[m] = 1'b0;
        end
      end else begin
        wr   = !load_main && !bus_dir;
        eff  = addr_load ? m_addr[m] : addr_in;
        pinc = !inc && addr_load;
        if (!addr_load) m_addr[m] = addr_in;
        if (wr && ws[m] == 0) begin
          model_write(m, eff, main_in);
          if (pinc) m_addr[m] = m_addr[m] + 16'd1;
        end else if (wr) begin
          m_pend[m]     = 1'b1;
          m_commit_t[m] = cyc + ws[m];
          m_paddr[m]    = eff;
          m_pdata[m]    = main_in;
          m_pinc[m]     = pinc;
        end else if (pinc) begin
          m_addr[m] = m_addr[m] + 16'd1;
        end
      end
      m_rd[m]       = nrd;
      m_rd_known[m] = nkn;
    end
    cyc++;
  endtask

  function automatic logic [34:0] dut_obs(input int m);
    if (m == 0) return {if0.main_out, if0.bus_out, if0.addr_out, if0.busy, if0.main_en, if0.wr_err};
    else        return {if3.main_out, if3.bus_out, if3.addr_out, if3.busy, if3.main_en, if3.wr_err};
  endfunction

  function automatic logic [34:0] mdl_obs(input int m);
    logic en;
    en = rst_n & bus_dir & !assert_main & !m_pend[m];
    return {m_rd[m], m_rd[m], m_addr[m], m_pend[m], en, m_err[m]};
  endfunction

  task automatic idle();
    addr_load = 1'b1; inc = 1'b1; load_main = 1'b1;
    bus_dir = 1'b1; assert_main = 1'b0; main_in = 8'h00; addr_in = 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Issue a write and leave enough edges for the slow DUT to commit.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    addr_load = 1'b0; addr_in = a; bus_dir = 1'b0; load_main = 1'b0; main_in = d;
    step();
    idle();
    repeat (3) step();
  endtask

  task automatic do_read(input logic [15:0] a);
    addr_load = 1'b0; addr_in = a;
    step();
    idle();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_obs(m) !== 35'h0) begin
        errors++; $display("FAIL reset_state dut%0d got=%h exp=%h", m, dut_obs(m), 35'h0);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({if0.main_en, if3.main_en} !== 2'b11) begin
      errors++; $display("FAIL reset_release_main_en got=%b exp=%b", {if0.main_en, if3.main_en}, 2'b11);
    end
  endtask

  task automatic test_write_read();
    addr_load = 1'b0; addr_in = 16'h8000;
    step();
    addr_load = 1'b1; bus_dir = 1'b0; main_in = 8'hAA; load_main = 1'b0;
    step();
    idle();
    step();
    checks++;
    if ({if0.bus_out, if0.main_out, if0.main_en} !== {8'hAA, 8'hAA, 1'b1}) begin
      errors++; $display("FAIL wr_rd_dut0 got=%h/%h/%b exp=aa/aa/1", if0.bus_out, if0.main_out, if0.main_en);
    end
    checks++;
    if ({if3.busy, if3.main_en} !== 2'b10) begin
      errors++; $display("FAIL wr_rd_dut3_busy got=%b exp=%b", {if3.busy, if3.main_en}, 2'b10);
    end
    repeat (3) step();
    checks++;
    if ({if3.bus_out, if3.main_en} !== {8'hAA, 1'b1}) begin
      errors++; $display("FAIL wr_rd_dut3 got=%h/%b exp=aa/1", if3.bus_out, if3.main_en);
    end
  endtask

  task automatic test_seq_fill();
    logic [7:0] vals [3];
    vals[0] = 8'h55; vals[1] = 8'h66; vals[2] = 8'h77;
    addr_load = 1'b0; addr_in = 16'h8001;
    step();
    for (int i = 0; i < 3; i++) begin
      addr_load = 1'b1; bus_dir = 1'b0; load_main = 1'b0; inc = 1'b0; main_in = vals[i];
      step();
      idle();
      repeat (3) step();
    end
    checks++;
    if ({if0.addr_out, if3.addr_out} !== {16'h8004, 16'h8004}) begin
      errors++; $display("FAIL fill_addr got=%h/%h exp=8004", if0.addr_out, if3.addr_out);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(16'h8001 + 16'(i));
      checks++;
      if ({if0.bus_out, if3.bus_out} !== {vals[i], vals[i]}) begin
        errors++; $display("FAIL fill_data[%0d] got=%h/%h exp=%h", i, if0.bus_out, if3.bus_out, vals[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    addr_load = 1'b0; addr_in = 16'h8000; bus_dir = 1'b0; load_main = 1'b0; main_in = 8'hC3;
    step();                                   // edge N
    checks++;
    if (if3.busy !== 1'b1) begin
      errors++; $display("FAIL ws_busy_n got=%b exp=1", if3.busy);
    end
    addr_in = 16'h8002; main_in = 8'hEE;
    step();                                   // edge N+1: ignored by the slow DUT
    checks++;
    if ({if3.busy, if3.addr_out, if0.addr_out} !== {1'b1, 16'h8000, 16'h8002}) begin
      errors++; $display("FAIL ws_ignore got=%b/%h/%h exp=1/8000/8002", if3.busy, if3.addr_out, if0.addr_out);
    end
    idle();
    step();                                   // edge N+2
    checks++;
    if (if3.busy !== 1'b1) begin
      errors++; $display("FAIL ws_busy_n2 got=%b exp=1", if3.busy);
    end
    step();                                   // edge N+3: commit, old data read
    checks++;
    if ({if3.busy, if3.bus_out} !== {1'b0, 8'hAA}) begin
      errors++; $display("FAIL ws_commit got=%b/%h exp=0/aa", if3.busy, if3.bus_out);
    end
    step();                                   // edge N+4
    checks++;
    if (if3.bus_out !== 8'hC3) begin
      errors++; $display("FAIL ws_newdata got=%h exp=c3", if3.bus_out);
    end
    do_read(16'h8002);
    checks++;
    if ({if3.bus_out, if0.bus_out} !== {8'h66, 8'hEE}) begin
      errors++; $display("FAIL ws_second_req got=%h/%h exp=66/ee", if3.bus_out, if0.bus_out);
    end
  endtask

  task automatic test_wrap();
    do_write(16'h0000, 8'h3C);
    addr_load = 1'b0; addr_in = 16'hFFFF;
    step();
    idle();
    inc = 1'b0;
    step();
    inc = 1'b1;
    checks++;
    if ({if0.addr_out, if3.addr_out} !== {16'h0000, 16'h0000}) begin
      errors++; $display("FAIL wrap_addr got=%h/%h exp=0000", if0.addr_out, if3.addr_out);
    end
    assert_main = 1'b1;
    step();
    checks++;
    if ({if0.main_en, if3.main_en} !== 2'b00) begin
      errors++; $display("FAIL nodrive_main_en got=%b exp=00", {if0.main_en, if3.main_en});
    end
    for (int m = 0; m < 2; m++) begin
      if (m_rd_known[m]) begin
        checks++;
        if (dut_obs(m)[26:19] !== m_rd[m]) begin
          errors++; $display("FAIL nodrive_bus_out dut%0d got=%h exp=%h", m, dut_obs(m)[26:19], m_rd[m]);
        end
      end
    end
    assert_main = 1'b0;
    #1;
    checks++;
    if ({if0.main_en, if3.main_en} !== 2'b11) begin
      errors++; $display("FAIL drive_main_en got=%b exp=11", {if0.main_en, if3.main_en});
    end
  endtask

  task automatic test_reset_mid_write();
    do_write(16'h9000, 8'hA5);
    addr_load = 1'b0; addr_in = 16'h9000; bus_dir = 1'b0; load_main = 1'b0; main_in = 8'h5A;
    step();
    idle();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_obs(m) !== 35'h0) begin
        errors++; $display("FAIL midreset_state dut%0d got=%h exp=%h", m, dut_obs(m), 35'h0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(16'h9000);
    checks++;
    if ({if3.bus_out, if0.bus_out} !== {8'hA5, 8'h5A}) begin
      errors++; $display("FAIL midreset_data got=%h/%h exp=a5/5a", if3.bus_out, if0.bus_out);
    end
  endtask

  task automatic test_rom_protect();
    logic [1:0] exp_err;
    exp_err = PROT ? 2'b11 : 2'b00;
    do_write(16'h7FFF, 8'h11);
    checks++;
    if ({if0.wr_err, if3.wr_err} !== exp_err) begin
      errors++; $display("FAIL rom_err got=%b exp=%b", {if0.wr_err, if3.wr_err}, exp_err);
    end
    if (!PROT) begin
      do_read(16'h7FFF);
      checks++;
      if ({if0.bus_out, if3.bus_out} !== {8'h11, 8'h11}) begin
        errors++; $display("FAIL rom_open_data got=%h/%h exp=11", if0.bus_out, if3.bus_out);
      end
    end
    do_write(16'h8000, 8'h22);
    do_read(16'h8000);
    checks++;
    if ({if0.bus_out, if3.bus_out, if0.wr_err, if3.wr_err} !== {8'h22, 8'h22, exp_err}) begin
      errors++; $display("FAIL rom_above got=%h/%h/%b exp=22/22/%b", if0.bus_out, if3.bus_out,
                         {if0.wr_err, if3.wr_err}, exp_err);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 10);
    if (r < 8)       return 16'h8000 + 16'(r);
    else if (r == 8) return 16'hFFFF;
    else if (r == 9) return 16'h7FFF;
    else             return 16'h0000;
  endfunction

  task automatic test_random();
    logic [34:0] mask;
    for (int i = 0; i < 400; i++) begin
      addr_load   = ($urandom_range(0, 3) != 0);
      addr_in     = pick_addr();
      inc         = addr_load ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_main   = ($urandom_range(0, 2) != 0);
      bus_dir     = ($urandom_range(0, 1) != 0);
      assert_main = ($urandom_range(0, 1) != 0);
      main_in     = 8'($urandom);
      step();
      for (int m = 0; m < 2; m++) begin
        mask = m_rd_known[m] ? {35{1'b1}} : {16'h0000, 19'h7FFFF};
        checks++;
        if ((dut_obs(m) & mask) !== (mdl_obs(m) & mask)) begin
          errors++; $display("FAIL random[%0d] dut%0d got=%h exp=%h", i, m, dut_obs(m) & mask, mdl_obs(m) & mask);
        end
      end
    end
  endtask

  initial begin
    ws[0] = 0;
    ws[1] = 3;
    test_reset();
    test_write_read();
    test_seq_fill();
    test_wait_states();
    test_wrap();
    test_reset_mid_write();
    test_rom_protect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
